// File: rtl/keccak_round_ctrl.sv
// Keccak-f[1600] round sequencer: walks the step unit through theta..iota for NUM_ROUNDS rounds.
// Optional abort input enabled by defining KECCAK_CTRL_ABORT_EN.
module keccak_round_ctrl #(
  parameter int unsigned NUM_ROUNDS       = 24,
  parameter int unsigned ROUND_INDEX_SIZE = 5,
  parameter int unsigned STEP_SEL_WIDTH   = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic                        hold_i,
`ifdef KECCAK_CTRL_ABORT_EN
  input  logic                        abort_i,
`endif
  output logic                        ready_o,
  output logic                        busy_o,
  output logic [STEP_SEL_WIDTH-1:0]   step_sel_o,
  output logic [ROUND_INDEX_SIZE-1:0] round_index_o,
  output logic                        state_we_o,
  output logic                        done_o
);

  typedef enum logic [2:0] {
    StIdle,
    StTheta,
    StRho,
    StPi,
    StChi,
    StIota,
    StDone
  } state_e;

  localparam logic [ROUND_INDEX_SIZE-1:0] LastRound = ROUND_INDEX_SIZE'(NUM_ROUNDS - 1);

  localparam logic [STEP_SEL_WIDTH-1:0] IdleStep  = STEP_SEL_WIDTH'(0);
  localparam logic [STEP_SEL_WIDTH-1:0] ThetaStep = STEP_SEL_WIDTH'(1);
  localparam logic [STEP_SEL_WIDTH-1:0] RhoStep   = STEP_SEL_WIDTH'(2);
  localparam logic [STEP_SEL_WIDTH-1:0] PiStep    = STEP_SEL_WIDTH'(3);
  localparam logic [STEP_SEL_WIDTH-1:0] ChiStep   = STEP_SEL_WIDTH'(4);
  localparam logic [STEP_SEL_WIDTH-1:0] IotaStep  = STEP_SEL_WIDTH'(5);

  state_e                      r_state;
  state_e                      w_state_nxt;
  logic [ROUND_INDEX_SIZE-1:0] r_round;
  logic [ROUND_INDEX_SIZE-1:0] w_round_nxt;
  logic                        w_abort;
  logic                        w_busy;

`ifdef KECCAK_CTRL_ABORT_EN
  assign w_abort = abort_i;
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_round <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_round <= w_round_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    case (r_state)
      StIdle: begin
        if (start_i) begin
          w_state_nxt = StTheta;
          w_round_nxt = '0;
        end
      end
      StTheta, StRho, StPi, StChi, StIota: begin
        // Abort outranks hold; hold freezes both the step and the round counter.
        if (w_abort) begin
          w_state_nxt = StIdle;
          w_round_nxt = '0;
        end else if (!hold_i) begin
          case (r_state)
            StTheta: w_state_nxt = StRho;
            StRho:   w_state_nxt = StPi;
            StPi:    w_state_nxt = StChi;
            StChi:   w_state_nxt = StIota;
            default: begin
              if (r_round < LastRound) begin
                w_state_nxt = StTheta;
                w_round_nxt = r_round + ROUND_INDEX_SIZE'(1);
              end else begin
                w_state_nxt = StDone;
              end
            end
          endcase
        end
      end
      default: begin
        w_state_nxt = StIdle;
        w_round_nxt = '0;
      end
    endcase
  end

  always_comb begin
    step_sel_o = IdleStep;
    case (r_state)
      StTheta: step_sel_o = ThetaStep;
      StRho:   step_sel_o = RhoStep;
      StPi:    step_sel_o = PiStep;
      StChi:   step_sel_o = ChiStep;
      StIota:  step_sel_o = IotaStep;
      default: step_sel_o = IdleStep;
    endcase
  end

  assign w_busy        = (r_state == StTheta) || (r_state == StRho) || (r_state == StPi) ||
                         (r_state == StChi) || (r_state == StIota);
  assign busy_o        = w_busy;
  assign ready_o       = (r_state == StIdle);
  assign done_o        = (r_state == StDone);
  assign state_we_o    = w_busy & ~hold_i & ~w_abort;
  assign round_index_o = r_round;

endmodule
